// File: rtl/nebula_packetizer.sv
// nebula_packetizer: turns one message of up to MAX_WORDS 32-bit words into a
// single NoC packet. A one-word message becomes one SINGLE flit. Longer
// messages become HEAD, BODY..., TAIL flits, one flit per payload word.
//
// Optional feature: define NEBULA_PACKETIZER_VC_ROTATE_EN to alternate vc_id
// 0,1,0,... per packet. With the macro undefined, every flit uses vc_id 0.
//
// The shared flit format lives in nebula_pkg, which is defined in this file.

package nebula_pkg;

    localparam int NOC_COORD_WIDTH    = 2;
    localparam int PACKET_ID_WIDTH    = 8;
    localparam int VC_ID_WIDTH        = 1;
    localparam int FLIT_PAYLOAD_WIDTH = 32;

    typedef enum logic [1:0] {
        FLIT_TYPE_HEAD   = 2'd0,
        FLIT_TYPE_BODY   = 2'd1,
        FLIT_TYPE_TAIL   = 2'd2,
        FLIT_TYPE_SINGLE = 2'd3
    } flit_type_e;

    typedef struct packed {
        flit_type_e                    flit_type;
        logic [VC_ID_WIDTH-1:0]        vc_id;
        logic [NOC_COORD_WIDTH-1:0]    src_x;
        logic [NOC_COORD_WIDTH-1:0]    src_y;
        logic [NOC_COORD_WIDTH-1:0]    dest_x;
        logic [NOC_COORD_WIDTH-1:0]    dest_y;
        logic [PACKET_ID_WIDTH-1:0]    packet_id;
        logic [FLIT_PAYLOAD_WIDTH-1:0] payload;
    } noc_flit_t;

endpackage

module nebula_packetizer
    import nebula_pkg::*;
#(
    parameter int COORD_WIDTH = 2,
    parameter int SRC_X       = 0,
    parameter int SRC_Y       = 0,
    parameter int MAX_WORDS   = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             msg_valid,
    output logic                             msg_ready,
    input  logic [COORD_WIDTH-1:0]           msg_dest_x,
    input  logic [COORD_WIDTH-1:0]           msg_dest_y,
    input  logic [$clog2(MAX_WORDS):0]       msg_len,
    input  logic [MAX_WORDS*32-1:0]          msg_data,
    output logic [PACKET_ID_WIDTH-1:0]       msg_pkt_id,
    output logic                             msg_err,
    output logic                             flit_out_valid,
    input  logic                             flit_out_ready,
    output noc_flit_t                        flit_out,
    output logic                             busy,
    output logic [15:0]                      pkt_sent_count
);

    localparam int LEN_W = $clog2(MAX_WORDS) + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // Control state. All of these registers are reset.
    logic [0:0]                 state_q,      state_d;
    logic                       ready_q,      ready_d;
    logic [PACKET_ID_WIDTH-1:0] pid_ctr_q,    pid_ctr_d;
    logic [PACKET_ID_WIDTH-1:0] cur_pid_q,    cur_pid_d;
    logic [PACKET_ID_WIDTH-1:0] msg_pkt_id_q, msg_pkt_id_d;
    logic                       msg_err_q,    msg_err_d;
    logic [LEN_W-1:0]           idx_q,        idx_d;
    logic [15:0]                sent_q,       sent_d;
    logic [VC_ID_WIDTH-1:0]     vc_ctr_q,     vc_ctr_d;
    logic [VC_ID_WIDTH-1:0]     cur_vc_q,     cur_vc_d;

    // Message datapath. It is loaded only on a legal accept.
    logic [COORD_WIDTH-1:0]     dest_x_q;
    logic [COORD_WIDTH-1:0]     dest_y_q;
    logic [LEN_W-1:0]           len_q;
    logic [MAX_WORDS*32-1:0]    data_q;

    logic                       accept;
    logic                       len_legal;
    logic                       load;
    logic                       flit_hs;
    logic                       is_last;
    logic [31:0]                payload;
    flit_type_e                 ftype;

    assign accept    = msg_valid && ready_q;
    assign len_legal = (msg_len != '0) && (msg_len <= LEN_W'(MAX_WORDS));
    assign load      = accept && len_legal;
    assign flit_hs   = (state_q == ST_SEND) && flit_out_ready;
    assign is_last   = ((idx_q + LEN_W'(1)) == len_q);

    // msg_ready has its own register so that it reads 0 while rst is high.
    // It then reads 1 from the first clock edge after rst is released.
    assign msg_ready      = ready_q;
    assign flit_out_valid = (state_q == ST_SEND);
    assign busy           = (state_q == ST_SEND);
    assign msg_pkt_id     = msg_pkt_id_q;
    assign msg_err        = msg_err_q;
    assign pkt_sent_count = sent_q;

    // Next-state logic: accept a message, step through its words, count finished packets.
    always_comb begin
        // NOTE: every _d signal gets a default here, so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d      = state_q;
        pid_ctr_d    = pid_ctr_q;
        cur_pid_d    = cur_pid_q;
        msg_pkt_id_d = msg_pkt_id_q;
        msg_err_d    = 1'b0;
        idx_d        = idx_q;
        sent_d       = sent_q;
        vc_ctr_d     = vc_ctr_q;
        cur_vc_d     = cur_vc_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (len_legal) begin
                        state_d      = ST_SEND;
                        idx_d        = '0;
                        cur_pid_d    = pid_ctr_q;
                        msg_pkt_id_d = pid_ctr_q;
                        // Packet id 0 is never issued: after all-ones the counter returns to 1.
                        pid_ctr_d    = (pid_ctr_q == '1) ? PACKET_ID_WIDTH'(1)
                                                         : pid_ctr_q + PACKET_ID_WIDTH'(1);
                        cur_vc_d     = vc_ctr_q;
`ifdef NEBULA_PACKETIZER_VC_ROTATE_EN
                        vc_ctr_d     = vc_ctr_q + VC_ID_WIDTH'(1);
`else
                        vc_ctr_d     = '0;
`endif
                    end else begin
                        msg_err_d = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (flit_hs) begin
                    idx_d = idx_q + LEN_W'(1);
                    if (is_last) begin
                        state_d = ST_IDLE;
                        if (sent_q != 16'hFFFF) begin
                            sent_d = sent_q + 16'd1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // Control registers: cleared asynchronously, so a partial packet is dropped at once.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples values from before the edge, whatever the statement order.
        if (rst) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b0;
            pid_ctr_q    <= PACKET_ID_WIDTH'(1);
            cur_pid_q    <= '0;
            msg_pkt_id_q <= '0;
            msg_err_q    <= 1'b0;
            idx_q        <= '0;
            sent_q       <= '0;
            vc_ctr_q     <= '0;
            cur_vc_q     <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            pid_ctr_q    <= pid_ctr_d;
            cur_pid_q    <= cur_pid_d;
            msg_pkt_id_q <= msg_pkt_id_d;
            msg_err_q    <= msg_err_d;
            idx_q        <= idx_d;
            sent_q       <= sent_d;
            vc_ctr_q     <= vc_ctr_d;
            cur_vc_q     <= cur_vc_d;
        end
    end

    // Message datapath registers: loaded on a legal accept and held for the whole packet.
    always_ff @(posedge clk) begin
        // NOTE: the payload registers are deliberately not reset. They are only
        // read while in SEND, after a load, and flit_out is forced to zero otherwise.
        if (load) begin
            dest_x_q <= msg_dest_x;
            dest_y_q <= msg_dest_y;
            len_q    <= msg_len;
            data_q   <= msg_data;
        end
    end

    // Flit assembly: select the current word and flit type, and drive zero when idle.
    always_comb begin
        payload = '0;
        for (int i = 0; i < MAX_WORDS; i++) begin
            if (idx_q == LEN_W'(i)) begin
                payload = data_q[32*i +: 32];
            end
        end

        if (len_q == LEN_W'(1)) begin
            ftype = FLIT_TYPE_SINGLE;
        end else if (idx_q == '0) begin
            ftype = FLIT_TYPE_HEAD;
        end else if (is_last) begin
            ftype = FLIT_TYPE_TAIL;
        end else begin
            ftype = FLIT_TYPE_BODY;
        end

        flit_out = '0;
        if (state_q == ST_SEND) begin
            flit_out.flit_type = ftype;
            flit_out.vc_id     = cur_vc_q;
            flit_out.src_x     = NOC_COORD_WIDTH'(SRC_X);
            flit_out.src_y     = NOC_COORD_WIDTH'(SRC_Y);
            flit_out.dest_x    = NOC_COORD_WIDTH'(dest_x_q);
            flit_out.dest_y    = NOC_COORD_WIDTH'(dest_y_q);
            flit_out.packet_id = cur_pid_q;
            flit_out.payload   = payload;
        end
    end

endmodule

// File: tb/tb_nebula_packetizer.sv
// Directed testbench for nebula_packetizer. It checks the block against
// hand-computed expected values, with a summary line at the end.
module tb_nebula_packetizer;
    import nebula_pkg::*;

`ifdef NEBULA_PACKETIZER_VC_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       msg_valid;
    logic                       msg_ready;
    logic [1:0]                 msg_dest_x;
    logic [1:0]                 msg_dest_y;
    logic [2:0]                 msg_len;
    logic [127:0]               msg_data;
    logic [PACKET_ID_WIDTH-1:0] msg_pkt_id;
    logic                       msg_err;
    logic                       flit_out_valid;
    logic                       flit_out_ready;
    noc_flit_t                  flit_out;
    logic                       busy;
    logic [15:0]                pkt_sent_count;

    int checks   = 0;
    int failures = 0;

    nebula_packetizer #(
        .COORD_WIDTH(2),
        .SRC_X      (2),
        .SRC_Y      (1),
        .MAX_WORDS  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .msg_valid     (msg_valid),
        .msg_ready     (msg_ready),
        .msg_dest_x    (msg_dest_x),
        .msg_dest_y    (msg_dest_y),
        .msg_len       (msg_len),
        .msg_data      (msg_data),
        .msg_pkt_id    (msg_pkt_id),
        .msg_err       (msg_err),
        .flit_out_valid(flit_out_valid),
        .flit_out_ready(flit_out_ready),
        .flit_out      (flit_out),
        .busy          (busy),
        .pkt_sent_count(pkt_sent_count)
    );

    always #5 clk = ~clk;

    // Watchdog: the run should end long before this time limit.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flit(input string tag, input noc_flit_t exp);
        checks++;
        assert (flit_out_valid === 1'b1 && flit_out === exp) else begin
            failures++;
            $error("FAIL %s: observed valid=%0b flit=%0h expected valid=1 flit=%0h",
                   tag, flit_out_valid, flit_out, exp);
        end
    endtask

    // The expected flit. Sender coordinates are (2,1), matching the instance parameters.
    function automatic noc_flit_t mk(input flit_type_e t, input int vc, input int dx,
                                     input int dy, input int pid, input logic [31:0] pl);
        noc_flit_t f;
        f           = '0;
        f.flit_type = t;
        f.vc_id     = ROT_EN ? VC_ID_WIDTH'(vc) : '0;
        f.src_x     = 2'd2;
        f.src_y     = 2'd1;
        f.dest_x    = NOC_COORD_WIDTH'(dx);
        f.dest_y    = NOC_COORD_WIDTH'(dy);
        f.packet_id = PACKET_ID_WIDTH'(pid);
        f.payload   = pl;
        return f;
    endfunction

    // Presents a message at a falling edge. The task returns at the next
    // falling edge, after the accept edge, with msg_valid dropped again.
    task automatic start_msg(input int dx, input int dy, input int len, input logic [127:0] data);
        msg_valid  = 1'b1;
        msg_dest_x = 2'(dx);
        msg_dest_y = 2'(dy);
        msg_len    = 3'(len);
        msg_data   = data;
        check("ready_before_accept", 32'(msg_ready), 32'd1);
        @(negedge clk);
        msg_valid = 1'b0;
    endtask

    task automatic flit_step(input string tag, input noc_flit_t exp);
        check_flit(tag, exp);
        @(negedge clk);
    endtask

    initial begin
        rst            = 1'b1;
        msg_valid      = 1'b0;
        msg_dest_x     = '0;
        msg_dest_y     = '0;
        msg_len        = '0;
        msg_data       = '0;
        flit_out_ready = 1'b1;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_msg_ready", 32'(msg_ready), 32'd0);
        check("rst_valid", 32'(flit_out_valid), 32'd0);
        check("rst_flit", flit_out[31:0], 32'd0);
        check("rst_flit_hi", 32'(flit_out[50:32]), 32'd0);
        check("rst_pkt_id", 32'(msg_pkt_id), 32'd0);
        check("rst_err", 32'(msg_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(pkt_sent_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(msg_ready), 32'd1);

        // Single word: packet id 1, one SINGLE flit one cycle after the accept edge
        start_msg(1, 0, 1, {96'b0, 32'hDEAD0001});
        check("single_pkt_id", 32'(msg_pkt_id), 32'd1);
        check("single_busy", 32'(busy), 32'd1);
        check("single_ready_low", 32'(msg_ready), 32'd0);
        flit_step("single_flit", mk(FLIT_TYPE_SINGLE, 0, 1, 0, 1, 32'hDEAD0001));
        check("single_valid_drop", 32'(flit_out_valid), 32'd0);
        check("single_count", 32'(pkt_sent_count), 32'd1);
        check("single_ready_back", 32'(msg_ready), 32'd1);

        // Three words: HEAD/BODY/TAIL on consecutive cycles, packet id 2
        start_msg(3, 2, 3, {32'h0, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001});
        flit_step("three_head", mk(FLIT_TYPE_HEAD, 1, 3, 2, 2, 32'hAAAA0001));
        flit_step("three_body", mk(FLIT_TYPE_BODY, 1, 3, 2, 2, 32'hBBBB0002));
        check_flit("three_tail", mk(FLIT_TYPE_TAIL, 1, 3, 2, 2, 32'hCCCC0003));
        check("three_tail_ready_low", 32'(msg_ready), 32'd0);
        @(negedge clk);
        check("gap_valid_low", 32'(flit_out_valid), 32'd0);
        check("gap_ready_high", 32'(msg_ready), 32'd1);
        check("three_count", 32'(pkt_sent_count), 32'd2);

        // Backpressure: HEAD held stable while ready is low for 5 cycles
        flit_out_ready = 1'b0;
        start_msg(2, 3, 2, {64'h0, 32'h22220002, 32'h11110001});
        for (int i = 0; i < 5; i++) begin
            flit_step("bp_hold_head", mk(FLIT_TYPE_HEAD, 0, 2, 3, 3, 32'h11110001));
        end
        flit_out_ready = 1'b1;
        flit_step("bp_head", mk(FLIT_TYPE_HEAD, 0, 2, 3, 3, 32'h11110001));
        flit_step("bp_tail", mk(FLIT_TYPE_TAIL, 0, 2, 3, 3, 32'h22220002));
        check("bp_valid_drop", 32'(flit_out_valid), 32'd0);
        check("bp_count", 32'(pkt_sent_count), 32'd3);

        // Illegal lengths 0 and 5: msg_err pulse, no flit, no id consumed
        msg_valid  = 1'b1;
        msg_dest_x = 2'd1;
        msg_dest_y = 2'd1;
        msg_len    = 3'd0;
        @(negedge clk);
        msg_valid = 1'b0;
        check("len0_err", 32'(msg_err), 32'd1);
        check("len0_valid", 32'(flit_out_valid), 32'd0);
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_pkt_id", 32'(msg_pkt_id), 32'd3);
        @(negedge clk);
        check("len0_err_pulse", 32'(msg_err), 32'd0);
        check("len0_no_flit", 32'(flit_out_valid), 32'd0);
        msg_valid = 1'b1;
        msg_len   = 3'd5;
        @(negedge clk);
        msg_valid = 1'b0;
        check("len5_err", 32'(msg_err), 32'd1);
        check("len5_valid", 32'(flit_out_valid), 32'd0);
        @(negedge clk);
        check("len5_err_pulse", 32'(msg_err), 32'd0);
        start_msg(0, 1, 1, {96'b0, 32'h44440004});
        check("after_err_pkt_id", 32'(msg_pkt_id), 32'd4);
        flit_step("after_err_flit", mk(FLIT_TYPE_SINGLE, 1, 0, 1, 4, 32'h44440004));
        check("after_err_count", 32'(pkt_sent_count), 32'd4);

        // Id wrap: ids 5..255, then 1 again. Packet n uses vc (n-1)%2.
        for (int id = 5; id <= 255; id++) begin
            start_msg(1, 1, 1, {96'b0, 32'(id)});
            flit_step("wrap_run", mk(FLIT_TYPE_SINGLE, (id - 1) % 2, 1, 1, id, 32'(id)));
        end
        start_msg(1, 2, 1, {96'b0, 32'h77770007});
        check("wrap_pkt_id", 32'(msg_pkt_id), 32'd1);
        flit_step("wrap_flit", mk(FLIT_TYPE_SINGLE, 1, 1, 2, 1, 32'h77770007));
        check("wrap_count", 32'(pkt_sent_count), 32'd256);

        // Reset during BODY of a 4-word packet (packet 257, id 2, vc 0)
        start_msg(2, 2, 4, {32'h55550004, 32'h55550003, 32'h55550002, 32'h55550001});
        flit_step("mid_head", mk(FLIT_TYPE_HEAD, 0, 2, 2, 2, 32'h55550001));
        check_flit("mid_body", mk(FLIT_TYPE_BODY, 0, 2, 2, 2, 32'h55550002));
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(flit_out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(msg_ready), 32'd0);
        check("mid_rst_count", 32'(pkt_sent_count), 32'd0);
        check("mid_rst_flit", flit_out[31:0], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(msg_ready), 32'd1);
        check("post_rst_count", 32'(pkt_sent_count), 32'd0);
        start_msg(3, 3, 1, {96'b0, 32'h66660006});
        check("post_rst_pkt_id", 32'(msg_pkt_id), 32'd1);
        flit_step("post_rst_flit", mk(FLIT_TYPE_SINGLE, 0, 3, 3, 1, 32'h66660006));
        check("post_rst_count_1", 32'(pkt_sent_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nebula_packetizer.md
NEBULA_PACKETIZER -- requirements
Module: nebula_packetizer

Interface
REQ-001 SHALL have parameter COORD_WIDTH, default 2: width of mesh coordinates.
REQ-002 SHALL have parameter SRC_X, default 0: x coordinate of the node, placed in every flit's src_x.
REQ-003 SHALL have parameter SRC_Y, default 0: y coordinate of the node, placed in every flit's src_y.
REQ-004 SHALL have parameter MAX_WORDS, default 4: maximum payload words per message.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port msg_valid, input, 1: message request valid.
REQ-008 SHALL have port msg_ready, output, 1: message accepted on the clk edge where msg_valid and msg_ready are both high.
REQ-009 SHALL have port msg_dest_x, input, COORD_WIDTH: destination x.
REQ-010 SHALL have port msg_dest_y, input, COORD_WIDTH: destination y.
REQ-011 SHALL have port msg_len, input, $clog2(MAX_WORDS)+1: number of words, legal range 1..MAX_WORDS.
REQ-012 SHALL have port msg_data, input, MAX_WORDS*32: payload; word i is at bits [32i+31:32i].
REQ-013 SHALL have port msg_pkt_id, output, PACKET_ID_WIDTH: packet_id assigned to the most recently accepted legal message.
REQ-014 SHALL have port msg_err, output, 1: one-cycle pulse when an illegal msg_len is accepted.
REQ-015 SHALL have port flit_out_valid, output, 1: flit valid towards the router local input port.
REQ-016 SHALL have port flit_out_ready, input, 1: router local input ready.
REQ-017 SHALL have port flit_out, output, noc_flit_t: flit to the router.
REQ-018 SHALL have port busy, output, 1: high while not IDLE.
REQ-019 SHALL have port pkt_sent_count, output, 16: count of fully transmitted packets.

Function
REQ-020 SHALL implement a two-state FSM: IDLE and SEND.
REQ-021 msg_ready SHALL equal (state==IDLE) and SHALL NOT depend on msg_valid.
REQ-022 On an accept with 1<=msg_len<=MAX_WORDS, the block SHALL:
- latch dest, len and data;
- assign packet_id = pid_ctr;
- update msg_pkt_id;
- advance pid_ctr;
- enter SEND with word index 0.
REQ-023 On an accept with msg_len==0 or msg_len>MAX_WORDS, the block SHALL pulse msg_err for one cycle, stay in IDLE, consume no packet_id and emit no flit.
REQ-024 pid_ctr SHALL reset to 1, increment by 1 per legal packet, and wrap from its all-ones value to 1 (0 is never issued).
REQ-025 flit_out_valid SHALL be registered, SHALL equal (state==SEND), and SHALL rise in the cycle after the accept edge (one-cycle latency).
REQ-026 While flit_out_valid is high and flit_out_ready is low, flit_out SHALL be held stable.
REQ-027 flit_out_valid SHALL never be deasserted before a handshake, except on reset.
REQ-028 Flit fields SHALL be:
- src = (SRC_X,SRC_Y);
- dest = latched dest;
- packet_id = assigned id;
- payload = word[index];
- flit_type = FLIT_TYPE_SINGLE if len==1, else HEAD at index 0, TAIL at index len-1, BODY otherwise.
REQ-029 On each flit handshake (flit_out_valid && flit_out_ready), index SHALL increment; on the SINGLE or TAIL handshake, the FSM SHALL return to IDLE.
REQ-030 Back-to-back messages SHALL incur exactly one idle cycle between the TAIL handshake and the next HEAD valid.
REQ-031 pkt_sent_count SHALL increment on each SINGLE or TAIL handshake and saturate at 0xFFFF.
REQ-032 The block SHALL sustain 1 flit per cycle while flit_out_ready is held high.

Reset
REQ-033 While rst is high, outputs SHALL be:
- msg_ready=0;
- flit_out_valid=0;
- flit_out='0;
- msg_pkt_id=0;
- msg_err=0;
- busy=0;
- pkt_sent_count=0.
Internal state SHALL be: state=IDLE, pid_ctr=1, index=0.
REQ-034 Reset asserted during SEND SHALL abandon the partial packet immediately (asynchronously), with no TAIL emitted and the count unchanged.
REQ-035 After rst deasserts, msg_ready SHALL be 1 from the first clk edge.

Configuration
REQ-036 Macro NEBULA_PACKETIZER_VC_ROTATE_EN SHALL control vc_id:
- defined: vc_id alternates 0,1,0,... per legal packet, starting at 0 after reset, and is constant across all flits of a packet;
- undefined: vc_id=0 for all flits.

Verification
REQ-037 A bench SHALL cover these scenarios:
- single word: len=1, dest (1,0), data 0xDEAD0001, ready=1 -> one SINGLE flit with packet_id=1, payload 0xDEAD0001, one cycle after accept; pkt_sent_count=1.
- three words: len=3, data A,B,C, ready=1 -> HEAD/A, BODY/B, TAIL/C on consecutive cycles, all packet_id=2, then msg_ready=1.
- backpressure: len=2, ready held low 5 cycles -> HEAD held stable for 5 cycles, then HEAD and TAIL delivered on ready.
- illegal length: len=0 -> msg_err pulse, no flit; the next legal message gets the next unused id.
- reset mid-packet: rst during the BODY of a 4-word packet -> valid=0 immediately; the next packet has id=1 and pkt_sent_count=0.
- VC rotation: with NEBULA_PACKETIZER_VC_ROTATE_EN defined, three packets -> vc_id 0,1,0.
